// File: rtl/mpu6050_burst_assembler.sv
// mpu6050_burst_assembler: packs the 14-byte MPU6050 burst into accel/temp/gyro words and commits them atomically
// Optional feature: define MPU_TEMP_CDEG_EN to emit temperature in 0.01 degC instead of the raw sensor word.
module mpu6050_burst_assembler #(
  parameter int NUM_BYTES   = 14,
  parameter int TIMEOUT_CYC = 4000,
  parameter int CNT_W       = 12
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        burst_start_i,
  input  logic        burst_abort_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        sample_ready_i,
  output logic [15:0] accel_x_o,
  output logic [15:0] accel_y_o,
  output logic [15:0] accel_z_o,
  output logic [15:0] temp_o,
  output logic [15:0] gyro_x_o,
  output logic [15:0] gyro_y_o,
  output logic [15:0] gyro_z_o,
  output logic        sample_valid_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        err_timeout_o
);
  typedef enum logic {IDLE, COLLECT} state_e;
  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [103:0]       sh_q, sh_d;
  logic [111:0]       data_q, data_d, burst;
  logic               valid_q, valid_d, ovr_q, ovr_d, tmo_q, tmo_d, commit;
  logic [15:0]        temp_val;

  // Bytes arrive strictly in order, so the shadow is a shift register; the 14th byte joins it at commit.
  assign burst = {sh_q, rx_data_i};

`ifdef MPU_TEMP_CDEG_EN
  logic signed [25:0] prod;
  assign prod     = $signed(burst[63:48]) * 26'sd301;
  assign temp_val = 16'((prod >>> 10) + 26'sd3653);
`else
  assign temp_val = burst[63:48];
`endif

  // Next-state: abort wins in COLLECT, burst_start (re)starts from index 0, otherwise collect bytes or age the timer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    sh_d    = sh_q;
    tmo_d   = 1'b0;
    commit  = 1'b0;
    if (state_q == COLLECT && burst_abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      timer_d = '0;
    end else if (burst_start_i) begin
      state_d = COLLECT;
      cnt_d   = rx_valid_i ? 4'd1 : 4'd0;
      timer_d = '0;
      sh_d    = rx_valid_i ? {sh_q[95:0], rx_data_i} : sh_q;
    end else if (state_q == COLLECT && rx_valid_i) begin
      timer_d = '0;
      commit  = cnt_q == 4'(NUM_BYTES - 1);
      state_d = commit ? IDLE : COLLECT;
      cnt_d   = commit ? 4'd0 : cnt_q + 4'd1;
      sh_d    = commit ? sh_q : {sh_q[95:0], rx_data_i};
    end else if (state_q == COLLECT) begin
      tmo_d   = timer_q == CNT_W'(TIMEOUT_CYC - 1);
      state_d = tmo_d ? IDLE : COLLECT;
      cnt_d   = tmo_d ? 4'd0 : cnt_q;
      timer_d = tmo_d ? '0 : timer_q + CNT_W'(1);
    end
  end

  // Output side: commit loads the whole sample at once; valid holds until accepted.
  always_comb begin
    data_d  = commit ? {burst[111:64], temp_val, burst[47:0]} : data_q;
    valid_d = commit | (valid_q & ~sample_ready_i);
    ovr_d   = commit & valid_q & ~sample_ready_i;
  end

  // Collection state registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      sh_q    <= sh_d;
    end
  end

  // Committed sample and status pulse registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign accel_x_o      = data_q[111:96];
  assign accel_y_o      = data_q[95:80];
  assign accel_z_o      = data_q[79:64];
  assign temp_o         = data_q[63:48];
  assign gyro_x_o       = data_q[47:32];
  assign gyro_y_o       = data_q[31:16];
  assign gyro_z_o       = data_q[15:0];
  assign sample_valid_o = valid_q;
  assign busy_o         = state_q == COLLECT;
  assign overrun_o      = ovr_q;
  assign err_timeout_o  = tmo_q;
endmodule

// File: tb/tb_mpu6050_burst_assembler.sv
// tb_mpu6050_burst_assembler: directed and random stimulus against a queue-based reference model
module tb_mpu6050_burst_assembler;
  localparam int TMO = 4000;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, rxv = 1'b0, ready = 1'b0;
  logic [7:0] rxd = '0;
  logic [15:0] ax, ay, az, tp, gx, gy, gz;
  logic valid, busy, ovr, tmo;
  int n_tests = 0, n_fail = 0, ovr_cnt = 0, tmo_cnt = 0;

  mpu6050_burst_assembler dut (
    .clk_i(clk), .reset_ni(reset_n), .burst_start_i(start), .burst_abort_i(abort),
    .rx_data_i(rxd), .rx_valid_i(rxv), .sample_ready_i(ready),
    .accel_x_o(ax), .accel_y_o(ay), .accel_z_o(az), .temp_o(tp),
    .gyro_x_o(gx), .gyro_y_o(gy), .gyro_z_o(gz),
    .sample_valid_o(valid), .busy_o(busy), .overrun_o(ovr), .err_timeout_o(tmo)
  );

  always #25 clk = ~clk;

  bit coll, ev, eo, et;
  logic [7:0] q[$];
  int idle;
  logic [15:0] ew[7];
  logic [7:0] bb[14];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] tconv(input logic [15:0] raw);
    int t;
`ifdef MPU_TEMP_CDEG_EN
    t = $signed(raw);
    t = ((t * 301) >>> 10) + 3653;
`else
    t = {16'b0, raw};
`endif
    return t[15:0];
  endfunction

  function automatic void m_reset();
    coll = 0; q.delete(); idle = 0; ev = 0; eo = 0; et = 0;
    foreach (ew[i]) ew[i] = '0;
  endfunction

  // Reference: a burst is a queue of bytes; 14 of them become seven big-endian words.
  function automatic void m_step(input bit s, input bit a, input bit v, input logic [7:0] d, input bit r);
    bit commit = 0;
    et = 0;
    if (coll && a) begin
      coll = 0; q.delete();
    end else if (s) begin
      coll = 1; q.delete(); idle = 0;
      if (v) q.push_back(d);
    end else if (coll && v) begin
      q.push_back(d); idle = 0;
      if (q.size() == 14) begin
        commit = 1; coll = 0;
        for (int i = 0; i < 7; i++) ew[i] = {q[2*i], q[2*i+1]};
        ew[3] = tconv(ew[3]);
        q.delete();
      end
    end else if (coll) begin
      idle++;
      if (idle == TMO) begin et = 1; coll = 0; q.delete(); idle = 0; end
    end
    eo = commit && ev && !r;
    ev = commit || (ev && !r);
  endfunction

  task automatic compare_all();
    check("accel_x", ax, ew[0]); check("accel_y", ay, ew[1]); check("accel_z", az, ew[2]);
    check("temp", tp, ew[3]); check("gyro_x", gx, ew[4]); check("gyro_y", gy, ew[5]);
    check("gyro_z", gz, ew[6]); check("sample_valid", valid, ev); check("busy", busy, coll);
    check("overrun", ovr, eo); check("err_timeout", tmo, et);
  endtask

  task automatic cyc(input bit s, input bit a, input bit v, input logic [7:0] d, input bit r);
    start = s; abort = a; rxv = v; rxd = d; ready = r;
    @(posedge clk);
    #1;
    if (!reset_n) m_reset(); else m_step(s, a, v, d, r);
    ovr_cnt += int'(ovr);
    tmo_cnt += int'(tmo);
    compare_all();
  endtask

  task automatic send(input bit r, input bit r_last);
    cyc(1, 0, 0, 8'h00, r);
    for (int i = 0; i < 14; i++) cyc(0, 0, 1, bb[i], i == 13 ? r_last : r);
  endtask

  initial begin
    // Reset and IDLE behaviour
    cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h77, 0);
    check("rst_accel_x", ax, 16'h0000); check("rst_valid", valid, 1'b0); check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 8'h55, 0);
    check("idle_rx_ignored", {valid, busy, ax}, 18'h0);
    // Basic burst and handshake
    foreach (bb[i]) bb[i] = 8'(i + 1);
    send(0, 0);
    check("ax_0102", ax, 16'h0102); check("ay_0304", ay, 16'h0304);
    check("gz_0d0e", gz, 16'h0D0E); check("valid_after_burst", valid, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0);
    check("held_ax", ax, 16'h0102); check("held_valid", valid, 1'b1);
    cyc(0, 0, 0, 8'h00, 1);
    check("valid_cleared", valid, 1'b0);
    // Timeout of a partial burst
    tmo_cnt = 0;
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'hEE, 0);
    for (int i = 0; i < TMO - 5; i++) cyc(0, 0, 0, 8'h00, 0);
    check("busy_before_timeout", busy, 1'b1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 8'h00, 0);
    check("timeout_pulses", tmo_cnt, 1);
    check("busy_after_timeout", busy, 1'b0); check("ax_after_timeout", ax, 16'h0102);
    // Restart mid-burst
    tmo_cnt = 0;
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 8'h33, 0);
    foreach (bb[i]) bb[i] = 8'(8'hA0 + i);
    send(0, 0);
    check("restart_ax", ax, 16'hA0A1); check("restart_no_err", tmo_cnt, 0);
    // Overrun on back-to-back bursts
    cyc(0, 0, 0, 8'h00, 1);
    ovr_cnt = 0;
    foreach (bb[i]) bb[i] = 8'($urandom);
    send(0, 0);
    foreach (bb[i]) bb[i] = 8'(8'h40 + i);
    send(0, 0);
    check("overrun_once", ovr_cnt, 1); check("overrun_ax", ax, 16'h4041); check("overrun_gz", gz, 16'h4C4D);
    // Temperature conversion
    bb[6] = 8'hF5; bb[7] = 8'h5C;
    ovr_cnt = 0;
    send(1, 0);
`ifdef MPU_TEMP_CDEG_EN
    check("temp_cdeg", tp, 16'd2852);
`else
    check("temp_raw", tp, 16'hF55C);
`endif
    // Commit coinciding with accept: no overrun
    send(0, 1);
    check("accept_commit_no_ovr", ovr_cnt, 0); check("accept_commit_valid", valid, 1'b1);
    // Abort beats rx_valid; abort in IDLE ignored
    cyc(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'h11, 0);
    cyc(0, 1, 1, 8'h22, 0);
    check("abort_idle", busy, 1'b0);
    cyc(0, 1, 0, 8'h00, 0);
    // Reset mid-burst
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h99, 0);
    reset_n = 1'b0;
    cyc(0, 0, 1, 8'h99, 0);
    check("midreset_clear", {busy, valid, ax, gz}, 34'h0);
    reset_n = 1'b1;
    // Random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(39) == 0, $urandom_range(149) == 0, $urandom_range(1) == 1,
          8'($urandom), $urandom_range(2) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
